ifetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of decode. Issues word-aligned PC read requests on the AXI4-Lite instruction-memory read channel. Buffers returned instructions with their PCs in a small FIFO and delivers them to decode via valid/ready. Handles control-flow redirects by flushing buffered and in-flight fetches.

---
 rtl/corerv_pkg.sv | 31 +++
 rtl/ifetch_fifo.sv | 72 +++++++
 rtl/ifetch_unit.sv | 187 ++++++++++++++++++
 tb/tb_ifetch_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/corerv_pkg.sv
// -----------------------------------------------------------------------------
// corerv_pkg
// Shared constants and types for the core front end.
//   XLEN / ILEN    : address and instruction widths
//   RESET_PC       : default first fetch address
//   axi_resp_e     : AXI read-response codes
//   fetch_entry_t  : one buffered fetch {instr, pc[, fault]}
// Optional feature macro: IFETCH_FAULT_EN adds the per-entry fault bit.
// -----------------------------------------------------------------------------
package corerv_pkg;

    localparam int unsigned     XLEN     = 32;
    localparam int unsigned     ILEN     = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_e;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
`ifdef IFETCH_FAULT_EN
        logic            fault;
`endif
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// -----------------------------------------------------------------------------
// ifetch_fifo
// Synchronous instruction buffer holding fetch_entry_t records.
//   clk, rst  : clock, synchronous active-high reset
//   i_flush   : empties the buffer (wins over push and pop)
//   i_push    : write i_din at the tail
//   i_din     : entry to write
//   i_pop     : drop the head entry (ignored while empty)
//   o_head    : head entry, all-zero while empty
//   o_count   : number of valid entries
//   o_empty   : no entries
//   o_full    : DEPTH entries
// Push and pop may happen together at any occupancy; a write becomes
// visible at the head one cycle later.
// -----------------------------------------------------------------------------
module ifetch_fifo
    import corerv_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  fetch_entry_t     i_din,
    input  logic             i_pop,
    output fetch_entry_t     o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty,
    output logic             o_full
);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));

    assign w_pop  = i_pop  & ~o_empty & ~i_flush;
    assign w_push = i_push & ~i_flush & (~o_full | w_pop);

    // NOTE: state updates use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // NOTE: the storage array is not reset; the head is masked while empty,
    // so stale contents can never reach decode.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_din;
    end

    assign o_head = o_empty ? '0 : r_mem[r_rptr];

endmodule

// File: rtl/ifetch_unit.sv
// -----------------------------------------------------------------------------
// ifetch_unit
// Instruction-fetch stage: issues word-aligned reads on the AXI4-Lite
// instruction read channel, buffers returned words with their PCs and hands
// them to decode over valid/ready. A redirect flushes buffered and in-flight
// fetches and restarts at the new target.
//   clk, rst             : clock, synchronous active-high reset
//   axi_imem_ar*         : read-address channel (araddr, arvalid, arready)
//   axi_imem_r*          : read-data channel (rdata, rresp, rvalid, rready)
//   redirect_valid/_pc   : one-cycle redirect from execute, pc[1:0] ignored
//   instr_valid/_ready   : decode handshake
//   instr, instr_pc      : instruction word and its PC
//   instr_fault          : head entry carried an error response
//                          (only with IFETCH_FAULT_EN)
// Optional feature macro: IFETCH_FAULT_EN.
// -----------------------------------------------------------------------------
module ifetch_unit #(
    parameter int unsigned     XLEN       = corerv_pkg::XLEN,
    parameter int unsigned     FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = corerv_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] axi_imem_araddr,
    output logic            axi_imem_arvalid,
    input  logic            axi_imem_arready,
    input  logic [31:0]     axi_imem_rdata,
    input  logic [1:0]      axi_imem_rresp,
    input  logic            axi_imem_rvalid,
    output logic            axi_imem_rready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc
`ifdef IFETCH_FAULT_EN
    ,
    output logic            instr_fault
`endif
);

    import corerv_pkg::*;

    localparam int unsigned      CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    // Registered state
    logic             r_arvalid;
    logic [XLEN-1:0]  r_araddr;
    logic [XLEN-1:0]  r_resp_pc;     // PC of the next response to be kept
    logic [XLEN-1:0]  r_target;      // redirect target parked behind a stale AR
    logic             r_stale;       // pending AR belongs to the old stream
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_discard;     // responses still to be dropped
    logic             r_fault_stop;

    // Combinational
    logic             w_ar_hs, w_r_hs, w_push, w_drop, w_pop, w_fault_push;
    logic             w_empty, w_full, w_credit;
    logic [CNT_W-1:0] w_count, w_out_n, w_cnt_n, w_discard_n;
    logic [XLEN-1:0]  w_redir_pc, w_araddr_n, w_resp_pc_n, w_target_n;
    logic             w_arvalid_n, w_stale_n, w_fault_n;
    fetch_entry_t     w_din, w_head;
    logic             w_unused;

    assign w_redir_pc = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_ar_hs    = r_arvalid & axi_imem_arready;
    // Credits guarantee FIFO room for every response, so R is always accepted.
    assign w_r_hs     = axi_imem_rvalid;
    assign w_drop     = w_r_hs & (r_discard != '0);
    // Responses arriving in a redirect cycle belong to the old stream.
    assign w_push     = w_r_hs & ~redirect_valid & (r_discard == '0);

    assign instr_valid = ~w_empty & ~redirect_valid;
    assign w_pop       = instr_valid & instr_ready;

    always_comb begin
        w_din       = '0;
        w_din.instr = axi_imem_rdata;
        w_din.pc    = r_resp_pc;
`ifdef IFETCH_FAULT_EN
        // SLVERR and DECERR both have bit 1 set.
        w_din.fault = axi_imem_rresp[1];
`endif
    end

`ifdef IFETCH_FAULT_EN
    assign w_fault_push = w_push & axi_imem_rresp[1];
`else
    assign w_fault_push = 1'b0;
`endif

    ifetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // NOTE: every signal driven here is given its hold value first, so no
    // path through the block can infer a latch.
    always_comb begin
        w_out_n     = r_outstanding + CNT_W'(w_ar_hs) - CNT_W'(w_r_hs);
        w_cnt_n     = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_discard_n = r_discard;
        w_araddr_n  = r_araddr;
        w_resp_pc_n = r_resp_pc;
        w_target_n  = r_target;
        w_stale_n   = r_stale;
        w_fault_n   = r_fault_stop;

        if (w_push)       w_resp_pc_n = r_resp_pc + XLEN'(4);
        if (w_drop)       w_discard_n = r_discard - 1'b1;
        if (w_ar_hs)      w_araddr_n  = r_araddr + XLEN'(4);
        if (w_fault_push) w_fault_n   = 1'b1;

        // A stale AR accepted now will return a word that must be dropped;
        // fetching then continues from the parked target.
        if (w_ar_hs && r_stale) begin
            w_discard_n = w_discard_n + 1'b1;
            w_araddr_n  = r_target;
            w_stale_n   = 1'b0;
        end

        if (redirect_valid) begin
            w_cnt_n     = '0;
            w_resp_pc_n = w_redir_pc;
            // Everything in flight after this cycle is old-stream traffic.
            w_discard_n = w_out_n;
            w_fault_n   = 1'b0;
            if (r_arvalid && !axi_imem_arready) begin
                // AR must stay stable until accepted: park the target.
                w_stale_n  = 1'b1;
                w_target_n = w_redir_pc;
            end else begin
                w_araddr_n = w_redir_pc;
                w_stale_n  = 1'b0;
            end
        end

        w_credit    = ({1'b0, w_out_n} + {1'b0, w_cnt_n}) < DEPTH_C;
        w_arvalid_n = (r_arvalid & ~axi_imem_arready) | (w_credit & ~w_fault_n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_arvalid     <= 1'b0;
            r_araddr      <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_target      <= RESET_PC;
            r_stale       <= 1'b0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_fault_stop  <= 1'b0;
        end else begin
            r_arvalid     <= w_arvalid_n;
            r_araddr      <= w_araddr_n;
            r_resp_pc     <= w_resp_pc_n;
            r_target      <= w_target_n;
            r_stale       <= w_stale_n;
            r_outstanding <= w_out_n;
            r_discard     <= w_discard_n;
            r_fault_stop  <= w_fault_n;
        end
    end

    assign axi_imem_araddr  = r_araddr;
    assign axi_imem_arvalid = r_arvalid;
    assign axi_imem_rready  = 1'b1;
    assign instr            = w_head.instr;
    assign instr_pc         = w_head.pc;
`ifdef IFETCH_FAULT_EN
    assign instr_fault      = w_head.fault;
`endif

    assign w_unused = ^{axi_imem_rresp, redirect_pc[1:0], w_full};

endmodule

// File: tb/tb_ifetch_unit.sv
// -----------------------------------------------------------------------------
// tb_ifetch_unit
// Self-checking bench for ifetch_unit. An in-order AXI read memory returns
// addr ^ salt; the reference model is simply "decode sees consecutive words
// starting at the last redirect target (or RESET_PC)".
// -----------------------------------------------------------------------------
module tb_ifetch_unit;

    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;
`ifdef IFETCH_FAULT_EN
    logic        instr_fault;
`endif

    always #5 clk = ~clk;

    ifetch_unit #(
        .XLEN       (32),
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (RST_PC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .axi_imem_araddr  (araddr),
        .axi_imem_arvalid (arvalid),
        .axi_imem_arready (arready),
        .axi_imem_rdata   (rdata),
        .axi_imem_rresp   (rresp),
        .axi_imem_rvalid  (rvalid),
        .axi_imem_rready  (rready),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr            (instr),
        .instr_pc         (instr_pc)
`ifdef IFETCH_FAULT_EN
        ,
        .instr_fault      (instr_fault)
`endif
    );

    typedef struct { logic [31:0] data; logic [1:0] resp; int due; } mem_rsp_t;
    typedef struct { logic [31:0] pc; logic [31:0] word; } got_t;
    typedef struct { logic [31:0] target; logic [31:0] exp0; logic [31:0] exp1; } redir_vec_t;

    mem_rsp_t    mem_q[$];
    logic [31:0] ar_log[$];
    got_t        got_q[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          tb_out = 0;
    int          lat_lo = 2, lat_hi = 2, stall_pct = 0;
    bit          resp_noise = 1'b0;
    logic [31:0] exp_pc, salt = '0, fault_addr = 32'hFFFF_FFF1, prev_araddr;
    logic        prev_ar_wait;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ar_at(input int i);
        if (i < ar_log.size()) return ar_log[i];
        return 'x;
    endfunction

    function automatic logic [31:0] got_pc(input int i);
        if (i < got_q.size()) return got_q[i].pc;
        return 'x;
    endfunction

    // One clock cycle: memory drives R, outputs are sampled away from the edge,
    // the model is advanced, then time moves to just after the next negedge.
    task automatic step();
        logic [1:0] rsp;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc && $urandom_range(99, 0) >= stall_pct) begin
            rvalid = 1'b1;
            rdata  = mem_q[0].data;
            rresp  = mem_q[0].resp;
        end else begin
            rvalid = 1'b0;
            rdata  = $urandom;
            rresp  = 2'b00;
        end
        #1;
        if (prev_ar_wait) check("ar_hold", {arvalid, araddr}, {1'b1, prev_araddr});
        check("rready", rready, 1'b1);
        if (instr_valid && instr_ready) begin
            check("deliver", {instr_pc, instr}, {exp_pc, exp_pc ^ salt});
            got_q.push_back('{instr_pc, instr});
            exp_pc = exp_pc + 32'd4;
        end
        if (redirect_valid) begin
            check("redir_hide", instr_valid, 1'b0);
            exp_pc = {redirect_pc[31:2], 2'b00};
        end
        if (arvalid && arready) begin
            rsp = (araddr == fault_addr) ? 2'b10 :
                  (resp_noise ? 2'($urandom_range(3, 0)) : 2'b00);
            mem_q.push_back('{araddr ^ salt, rsp, cyc + int'($urandom_range(lat_hi, lat_lo))});
            ar_log.push_back(araddr);
            tb_out++;
        end
        if (rvalid) begin
            void'(mem_q.pop_front());
            tb_out--;
        end
        check("credit", (tb_out >= 0 && tb_out <= DEPTH), 1'b1);
        prev_ar_wait = arvalid && !arready;
        prev_araddr  = araddr;
        @(negedge clk);
        redirect_valid = 1'b0;
        cyc++;
        #1;
    endtask

    task automatic do_reset(input logic [31:0] s);
        rst = 1'b1; arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
        redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        mem_q.delete(); ar_log.delete(); got_q.delete();
        tb_out = 0; prev_ar_wait = 1'b0; exp_pc = RST_PC; salt = s;
        @(posedge clk); @(posedge clk); #1;
        check("rst_ctrl", {arvalid, instr_valid, rready, araddr}, {1'b0, 1'b0, 1'b1, RST_PC});
        check("rst_data", {instr_pc, instr}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        redir_vec_t vecs[4];
        int n0, na, n10, cnt;

        vecs[0] = '{32'h0000_0200, 32'h0000_0200, 32'h0000_0204};
        vecs[1] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104};
        vecs[2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[3] = '{32'h0000_0007, 32'h0000_0004, 32'h0000_0008};

        // Streaming with fixed 2-cycle memory latency.
        do_reset(32'h0);
        arready = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        n10 = got_q.size();
        for (int i = 0; i < 10; i++) step();
        for (int i = 0; i < 4; i++) check("t1_araddr", ar_at(i), 32'(4 * i));
        for (int i = 0; i < 3; i++)
            check("t1_pair", {got_pc(i), (i < got_q.size()) ? got_q[i].word : 32'hx},
                  {32'(4 * i), 32'(4 * i)});
        check("t1_rate", got_q.size() - n10, 10);

        // Decode stalled: credits cap the requests at the FIFO depth.
        do_reset(32'h0);
        arready = 1'b1; instr_ready = 1'b0;
        for (int i = 0; i < 30; i++) step();
        check("t2_ar_cap", ar_log.size(), DEPTH);
        check("t2_ar_idle", arvalid, 1'b0);
        instr_ready = 1'b1;
        for (int i = 0; i < 40; i++) step();
        check("t2_resume", ar_log.size() > DEPTH, 1'b1);
        check("t2_flow", got_q.size() >= 30, 1'b1);

        // AR held while arready is low.
        do_reset(32'h0);
        arready = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 40 && !(arvalid && araddr == 32'h10); i++) step();
        check("t3_reach", {arvalid, araddr}, {1'b1, 32'h10});
        arready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t3_hold", {arvalid, araddr}, {1'b1, 32'h10});
            step();
        end
        arready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        cnt = 0;
        foreach (ar_log[i]) if (ar_log[i] == 32'h10) cnt++;
        check("t3_once", cnt, 1);

        // Redirect table: requests in flight plus buffered data are flushed.
        foreach (vecs[v]) begin
            do_reset(32'h0);
            arready = 1'b1; instr_ready = 1'b0;
            for (int i = 0; i < 50 && !(tb_out >= 2 && instr_valid); i++) step();
            check("t4_setup", (tb_out >= 2 && instr_valid), 1'b1);
            n0 = got_q.size();
            redirect_valid = 1'b1; redirect_pc = vecs[v].target; instr_ready = 1'b1;
            step();
            for (int i = 0; i < 60 && got_q.size() < n0 + 2; i++) step();
            check("t4_first", got_pc(n0), vecs[v].exp0);
            check("t4_second", got_pc(n0 + 1), vecs[v].exp1);
        end

        // Redirect while an AR is stuck: old AR completes, then the target.
        do_reset(32'h0);
        arready = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 60 && !(arvalid && araddr == 32'h40); i++) step();
        check("t5_reach", {arvalid, araddr}, {1'b1, 32'h40});
        na = ar_log.size(); n0 = got_q.size();
        arready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h103;
        step(); step(); step();
        arready = 1'b1;
        for (int i = 0; i < 40 && !(ar_log.size() >= na + 2 && got_q.size() > n0); i++) step();
        check("t5_old_ar", ar_at(na), 32'h40);
        check("t5_new_ar", ar_at(na + 1), 32'h100);
        check("t5_first", got_pc(n0), 32'h100);

`ifdef IFETCH_FAULT_EN
        // Error response stops fetching until a redirect.
        do_reset(32'h0);
        fault_addr = 32'h8;
        arready = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 40 && !(instr_valid && instr_pc == 32'h8); i++) step();
        check("t6_fault", {instr_valid, instr_fault, instr_pc}, {1'b1, 1'b1, 32'h8});
        instr_ready = 1'b0;
        na = ar_log.size();
        for (int i = 0; i < 20; i++) step();
        check("t6_stop", {arvalid, 32'(ar_log.size() - na)}, 33'h0);
        fault_addr = 32'hFFFF_FFF1;
        n0 = got_q.size(); na = ar_log.size();
        redirect_valid = 1'b1; redirect_pc = 32'h0; instr_ready = 1'b1;
        step();
        for (int i = 0; i < 40 && got_q.size() <= n0; i++) step();
        check("t6_restart", got_pc(n0), 32'h0);
        check("t6_ar_again", ar_log.size() > na, 1'b1);
`endif

        // Random traffic against the stream model.
        do_reset($urandom);
`ifdef IFETCH_FAULT_EN
        resp_noise = 1'b0;
`else
        resp_noise = 1'b1;
`endif
        lat_lo = 1; lat_hi = 4; stall_pct = 20;
        for (int i = 0; i < 3000; i++) begin
            arready     = ($urandom_range(99, 0) < 70);
            instr_ready = ($urandom_range(99, 0) < 60);
            if ($urandom_range(99, 0) < 3) begin
                redirect_valid = 1'b1;
                redirect_pc = ($urandom_range(3, 0) == 0) ?
                              (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) :
                              ($urandom & 32'h0000_FFFF);
            end
            step();
        end
        check("rand_progress", got_q.size() > 100, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
